// File: rtl/io_bus_pkg.sv
// Shared types and constants for the peripheral register-port arbiter.
//   arb_state_t : arbiter FSM states (IDLE = round robin, LOCKED = one owner)
//   IO_ADDR_W   : iosystem address width
//   IO_DATA_W   : iosystem data width
//   io_be_t     : byte-lane enable, same encoding as iosystem dwrite_en
package io_bus_pkg;

  localparam int IO_ADDR_W = 16;
  localparam int IO_DATA_W = 16;

  typedef logic [1:0] io_be_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_i     : per-requester request vector
//   pointer_i : index holding highest priority this cycle
//   gnt_o     : one-hot grant (all zero when nothing requests)
//   winner_o  : index of the granted requester (0 when nothing requests)
module rr_arbiter #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] pointer_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] winner_o
);

  // Scan N positions starting at the pointer; the first requester found wins.
  always_comb begin
    int   idx;
    logic found;
    gnt_o    = '0;
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(pointer_i) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        winner_o   = W'(idx);
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares the single iosystem register port between NUM_MASTERS requesters
// (m0 = CPU, m1 = debug/DMA) with round-robin arbitration, one access per
// cycle, and an optional bus lock for read-modify-write sequences.
//
// Ports
//   clk, reset         : clock (posedge), asynchronous active-low reset
//   m_req/m_we/m_lock  : per-master request, write flag, lock request
//   m_addr/m_wdata     : per-master 16-bit address / write data (packed)
//   m_be               : per-master 2-bit byte enables (packed)
//   m_gnt              : one-hot grant, the access is issued this cycle
//   m_rvalid, m_rdata  : one-hot read-return valid, shared read data
//   lock_abort         : one-cycle pulse when a lock is forcibly released
//   io_dread_addr/data : iosystem read port
//   io_dwrite_addr/data/en : iosystem write port
//   dbg_state          : current arbiter FSM state
//
// Handshake: a master raises m_req with we/lock/addr/wdata/be and holds them
// stable until it sees m_gnt high in the same cycle; the access is issued in
// that cycle. It may drop m_req before a grant to withdraw. Read data comes
// back as m_rvalid (one-hot) with m_rdata exactly one cycle after the grant;
// there is no backpressure on the return path.
module io_bus_arbiter
  import io_bus_pkg::*;
#(
  parameter int                   NUM_MASTERS     = 2,
  parameter int                   LOCK_MAX_CYCLES = 15,
  parameter logic [IO_ADDR_W-1:0] IDLE_ADDR       = 16'hFFFE
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_MASTERS-1:0]         m_req,
  input  logic [NUM_MASTERS-1:0]         m_we,
  input  logic [NUM_MASTERS-1:0]         m_lock,
  input  logic [NUM_MASTERS*IO_ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*IO_DATA_W-1:0] m_wdata,
  input  logic [NUM_MASTERS*2-1:0]       m_be,
  output logic [NUM_MASTERS-1:0]         m_gnt,
  output logic [NUM_MASTERS-1:0]         m_rvalid,
  output logic [IO_DATA_W-1:0]           m_rdata,
  output logic                           lock_abort,
  output logic [IO_ADDR_W-1:0]           io_dread_addr,
  input  logic [IO_DATA_W-1:0]           io_dread_data,
  output logic [IO_ADDR_W-1:0]           io_dwrite_addr,
  output logic [IO_DATA_W-1:0]           io_dwrite_data,
  output io_be_t                         io_dwrite_en,
  output arb_state_t                     dbg_state
);

  localparam int         PTR_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_MASTERS - 1);

  arb_state_t             state_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       owner_q;
  logic [7:0]             count_q;
  logic                   lock_abort_q;
  logic [NUM_MASTERS-1:0] rvalid_q;
  logic [IO_DATA_W-1:0]   rdata_q;

  logic [NUM_MASTERS-1:0] owner_mask;
  logic [NUM_MASTERS-1:0] req_elig;
  logic [NUM_MASTERS-1:0] gnt_raw;
  logic [NUM_MASTERS-1:0] gnt;
  logic [PTR_W-1:0]       win;
  logic [PTR_W-1:0]       ptr_next;
  logic [PTR_W-1:0]       owner_next;
  logic                   any_gnt;
  logic                   win_we;
  logic                   win_lock;
  logic [IO_ADDR_W-1:0]   win_addr;
  logic [IO_DATA_W-1:0]   win_wdata;
  io_be_t                 win_be;

  assign owner_mask = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner_q;

  // While locked, every master except the owner is masked out of arbitration.
  always_comb begin
    req_elig = m_req;
    if (state_q == LOCKED) req_elig = m_req & owner_mask;
  end

  rr_arbiter #(
    .N (NUM_MASTERS),
    .W (PTR_W)
  ) u_rr (
    .req_i     (req_elig),
    .pointer_i (ptr_q),
    .gnt_o     (gnt_raw),
    .winner_o  (win)
  );

  // Grants are held off combinationally during reset.
  assign gnt     = reset ? gnt_raw : '0;
  assign any_gnt = |gnt;

  assign win_we    = m_we[win];
  assign win_lock  = m_lock[win];
  assign win_addr  = m_addr[int'(win)*IO_ADDR_W +: IO_ADDR_W];
  assign win_wdata = m_wdata[int'(win)*IO_DATA_W +: IO_DATA_W];
  assign win_be    = m_be[int'(win)*2 +: 2];

  assign ptr_next   = (win == PTR_MAX) ? '0 : win + PTR_W'(1);
  assign owner_next = (owner_q == PTR_MAX) ? '0 : owner_q + PTR_W'(1);

  // Unused port of the pair is parked on IDLE_ADDR with enables low.
  always_comb begin
    io_dread_addr  = IDLE_ADDR;
    io_dwrite_addr = IDLE_ADDR;
    io_dwrite_data = '0;
    io_dwrite_en   = '0;
    if (any_gnt) begin
      io_dwrite_data = win_wdata;
      if (win_we) begin
        io_dwrite_addr = win_addr;
        io_dwrite_en   = win_be;
      end else begin
        io_dread_addr  = win_addr;
      end
    end
  end

  // Arbiter FSM, rr pointer, lock counter and the abort pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      count_q      <= '0;
      lock_abort_q <= 1'b0;
    end else begin
      lock_abort_q <= 1'b0;
      if (any_gnt) ptr_q <= ptr_next;
      case (state_q)
        IDLE: begin
          if (any_gnt && win_lock) begin
            state_q <= LOCKED;
            owner_q <= win;
            count_q <= '0;
          end
        end
        LOCKED: begin
          count_q <= count_q + 8'd1;
          // A voluntary release wins over a timeout landing in the same cycle.
          if (!m_lock[owner_q]) begin
            state_q <= IDLE;
          end else if (count_q == LOCK_LAST) begin
            state_q      <= IDLE;
            lock_abort_q <= 1'b1;
            // Skip the owner so it cannot re-lock straight away.
            ptr_q        <= owner_next;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read-return pipeline: one stage, so back-to-back reads return back to back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= (any_gnt && !win_we) ? gnt : '0;
      if (any_gnt && !win_we) rdata_q <= io_dread_data;
    end
  end

  assign m_gnt      = gnt;
  assign m_rvalid   = rvalid_q;
  assign m_rdata    = rdata_q;
  assign lock_abort = lock_abort_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
module tb_io_bus_arbiter;
  import io_bus_pkg::*;

  localparam int N       = 2;
  localparam int LOCKMAX = 4;
  localparam logic [15:0] IDLE_A = 16'hFFFE;
  localparam logic [15:0] RD_KEY = 16'h5A3C;

  logic        clk;
  logic        reset;
  logic [1:0]  m_req, m_we, m_lock;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic [1:0]  m_gnt, m_rvalid;
  logic [15:0] m_rdata;
  logic        lock_abort;
  logic [15:0] io_dread_addr, io_dread_data, io_dwrite_addr, io_dwrite_data;
  io_be_t      io_dwrite_en;
  arb_state_t  dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  io_bus_arbiter #(
    .NUM_MASTERS     (N),
    .LOCK_MAX_CYCLES (LOCKMAX),
    .IDLE_ADDR       (IDLE_A)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .m_req          (m_req),
    .m_we           (m_we),
    .m_lock         (m_lock),
    .m_addr         (m_addr),
    .m_wdata        (m_wdata),
    .m_be           (m_be),
    .m_gnt          (m_gnt),
    .m_rvalid       (m_rvalid),
    .m_rdata        (m_rdata),
    .lock_abort     (lock_abort),
    .io_dread_addr  (io_dread_addr),
    .io_dread_data  (io_dread_data),
    .io_dwrite_addr (io_dwrite_addr),
    .io_dwrite_data (io_dwrite_data),
    .io_dwrite_en   (io_dwrite_en),
    .dbg_state      (dbg_state)
  );

  // Peripheral stand-in: read data is a fixed scramble of the address.
  assign io_dread_data = io_dread_addr ^ RD_KEY;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // Model state: priority index, lock owner and number of locked cycles
  // served, the read owed next cycle, and an abort owed next cycle.
  int          mdl_ptr = 0;
  bit          mdl_locked = 1'b0;
  int          mdl_owner = 0;
  int          mdl_served = 0;
  int          mdl_rv = -1;
  logic [15:0] mdl_rdata = '0;
  bit          mdl_abort = 1'b0;

  always @(negedge clk) begin : compare_proc
    int          w;
    int          cand;
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rv;
    logic [15:0] exp_dr, exp_dw, exp_wd, a;
    logic [1:0]  exp_en;
    if (!reset) begin
      check("rst_gnt", 32'(m_gnt), 32'(0));
      check("rst_rvalid", 32'(m_rvalid), 32'(0));
      check("rst_abort", 32'(lock_abort), 32'(0));
      check("rst_wen", 32'(io_dwrite_en), 32'(0));
      check("rst_draddr", 32'(io_dread_addr), 32'(IDLE_A));
      check("rst_dwaddr", 32'(io_dwrite_addr), 32'(IDLE_A));
      mdl_ptr = 0; mdl_locked = 1'b0; mdl_owner = 0; mdl_served = 0;
      mdl_rv = -1; mdl_abort = 1'b0;
    end else begin
      exp_rv = (mdl_rv >= 0) ? (2'b01 << mdl_rv) : 2'b00;
      check("rvalid", 32'(m_rvalid), 32'(exp_rv));
      if (mdl_rv >= 0) check("rdata", 32'(m_rdata), 32'(mdl_rdata));
      check("lock_abort", 32'(lock_abort), 32'(mdl_abort));
      check("state", 32'(dbg_state == LOCKED), 32'(mdl_locked));

      w = -1;
      for (int k = 0; k < N; k++) begin
        cand = (mdl_ptr + k) % N;
        if (w < 0 && m_req[cand] && (!mdl_locked || cand == mdl_owner)) w = cand;
      end
      exp_gnt = (w >= 0) ? (2'b01 << w) : 2'b00;
      exp_dr = IDLE_A; exp_dw = IDLE_A; exp_en = 2'b00; exp_wd = 16'h0;
      if (w >= 0) begin
        a = m_addr[w*16 +: 16];
        if (m_we[w]) begin
          exp_dw = a; exp_en = m_be[w*2 +: 2]; exp_wd = m_wdata[w*16 +: 16];
        end else begin
          exp_dr = a;
        end
      end
      check("gnt", 32'(m_gnt), 32'(exp_gnt));
      check("dread_addr", 32'(io_dread_addr), 32'(exp_dr));
      check("dwrite_addr", 32'(io_dwrite_addr), 32'(exp_dw));
      check("dwrite_en", 32'(io_dwrite_en), 32'(exp_en));
      if (w >= 0 && m_we[w]) check("dwrite_data", 32'(io_dwrite_data), 32'(exp_wd));

      // advance the model to the next cycle
      mdl_abort = 1'b0;
      mdl_rv = -1;
      if (w >= 0) begin
        mdl_ptr = (w + 1) % N;
        if (!m_we[w]) begin
          mdl_rv = w;
          mdl_rdata = exp_dr ^ RD_KEY;
        end
      end
      if (!mdl_locked) begin
        if (w >= 0 && m_lock[w]) begin
          mdl_locked = 1'b1; mdl_owner = w; mdl_served = 0;
        end
      end else begin
        mdl_served++;
        if (!m_lock[mdl_owner]) begin
          mdl_locked = 1'b0;
        end else if (mdl_served == LOCKMAX) begin
          mdl_locked = 1'b0;
          mdl_abort = 1'b1;
          mdl_ptr = (mdl_owner + 1) % N;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_all();
    m_req = '0; m_we = '0; m_lock = '0; m_addr = '0; m_wdata = '0; m_be = '0;
  endtask

  task automatic set_m(input int m, input bit req, input bit we, input bit lock,
                       input logic [15:0] addr, input logic [15:0] wdata, input logic [1:0] be);
    m_req[m] = req; m_we[m] = we; m_lock[m] = lock;
    m_addr[m*16 +: 16] = addr; m_wdata[m*16 +: 16] = wdata; m_be[m*2 +: 2] = be;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_all();
    tick();
    tick();
    reset = 1'b1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b0;
    clear_all();
    // Requests during reset must not be granted.
    m_req = 2'b11;
    mid();
    check("lit_reset_gnt", 32'(m_gnt), 32'(2'b00));
    check("lit_reset_draddr", 32'(io_dread_addr), 32'(16'hFFFE));
    tick();

    // 1: single write from m0
    do_reset();
    set_m(0, 1, 1, 0, 16'h0018, 16'h00A5, 2'b01);
    mid();
    check("lit_t1_gnt", 32'(m_gnt), 32'(2'b01));
    check("lit_t1_wen", 32'(io_dwrite_en), 32'(2'b01));
    check("lit_t1_waddr", 32'(io_dwrite_addr), 32'(16'h0018));
    check("lit_t1_wdata", 32'(io_dwrite_data), 32'(16'h00A5));
    tick();
    clear_all();
    tick();

    // 2: both masters request every cycle -> strict alternation from m0
    do_reset();
    set_m(0, 1, 0, 0, 16'h0100, 16'h0, 2'b00);
    set_m(1, 1, 0, 0, 16'h0200, 16'h0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      mid();
      check("lit_t2_gnt", 32'(m_gnt), (i % 2 == 0) ? 32'(2'b01) : 32'(2'b10));
      tick();
    end
    clear_all();
    tick();

    // 3: back-to-back reads from m1
    do_reset();
    set_m(1, 1, 0, 0, 16'h002C, 16'h0, 2'b00);
    mid();
    check("lit_t3_gnt0", 32'(m_gnt), 32'(2'b10));
    tick();
    set_m(1, 1, 0, 0, 16'h002E, 16'h0, 2'b00);
    mid();
    check("lit_t3_rv1", 32'(m_rvalid), 32'(2'b10));
    check("lit_t3_rd1", 32'(m_rdata), 32'(16'h5A10));
    tick();
    clear_all();
    mid();
    check("lit_t3_rv2", 32'(m_rvalid), 32'(2'b10));
    check("lit_t3_rd2", 32'(m_rdata), 32'(16'h5A12));
    tick();
    mid();
    check("lit_t3_rv3", 32'(m_rvalid), 32'(2'b00));
    tick();

    // 4: m0 locks for 3 cycles, m1 waits until after the release cycle
    do_reset();
    set_m(1, 1, 0, 0, 16'h0050, 16'h0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      set_m(0, 1, 1, 1, 16'h0040, 16'(16'h0010 + i), 2'b11);
      mid();
      check("lit_t4_lockgnt", 32'(m_gnt), 32'(2'b01));
      tick();
    end
    set_m(0, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    mid();
    check("lit_t4_release_gnt", 32'(m_gnt), 32'(2'b00));
    check("lit_t4_release_state", 32'(dbg_state == LOCKED), 32'(1));
    tick();
    mid();
    check("lit_t4_m1_gnt", 32'(m_gnt), 32'(2'b10));
    check("lit_t4_abort", 32'(lock_abort), 32'(0));
    tick();
    clear_all();
    mid();
    check("lit_t4_rv", 32'(m_rvalid), 32'(2'b10));
    tick();

    // 5: lock timeout after LOCKMAX locked cycles, then m1 goes first
    do_reset();
    set_m(0, 1, 1, 1, 16'h0060, 16'h1234, 2'b11);
    set_m(1, 1, 0, 0, 16'h0070, 16'h0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      mid();
      check("lit_t5_owner_gnt", 32'(m_gnt), 32'(2'b01));
      check("lit_t5_no_abort", 32'(lock_abort), 32'(0));
      tick();
    end
    mid();
    check("lit_t5_abort", 32'(lock_abort), 32'(1));
    check("lit_t5_m1_first", 32'(m_gnt), 32'(2'b10));
    tick();
    set_m(1, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    mid();
    check("lit_t5_abort_1cyc", 32'(lock_abort), 32'(0));
    check("lit_t5_m0_again", 32'(m_gnt), 32'(2'b01));
    tick();
    clear_all();
    tick();
    tick();

    // lock drop coinciding with the timeout cycle is a normal release
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_m(0, 1, 1, 1, 16'h0080, 16'(i), 2'b10);
      tick();
    end
    set_m(0, 1, 1, 0, 16'h0080, 16'h0004, 2'b10);
    tick();
    clear_all();
    mid();
    check("lit_drop_timeout_abort", 32'(lock_abort), 32'(0));
    check("lit_drop_timeout_state", 32'(dbg_state == LOCKED), 32'(0));
    tick();

    // 6: reset in the cycle after a read grant kills the response and the pointer
    do_reset();
    set_m(0, 1, 0, 0, 16'h0030, 16'h0, 2'b00);
    mid();
    check("lit_t6_gnt", 32'(m_gnt), 32'(2'b01));
    tick();
    reset = 1'b0;
    set_m(0, 1, 0, 0, 16'h0032, 16'h0, 2'b00);
    set_m(1, 1, 0, 0, 16'h0034, 16'h0, 2'b00);
    mid();
    check("lit_t6_rv", 32'(m_rvalid), 32'(2'b00));
    check("lit_t6_wen", 32'(io_dwrite_en), 32'(2'b00));
    check("lit_t6_gnt_rst", 32'(m_gnt), 32'(2'b00));
    tick();
    reset = 1'b1;
    mid();
    check("lit_t6_first", 32'(m_gnt), 32'(2'b01));
    tick();
    clear_all();
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
